// File: rtl/activation_sequencer.sv
// activation_sequencer: streams one output tile of rows through the shared
// activation unit and collects the results into a small output FIFO.
// The activation unit cannot stall, so a row is only issued when the FIFO
// is guaranteed to have room for its result (credit = FIFO space minus rows
// already in flight inside the unit).
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; latched config still drives act_type/act_enable
// ISSUE | accepting rows from upstream and forwarding them to the unit
// DRAIN | all rows issued; waiting for results to return and FIFO to empty
// DONE  | one-cycle completion pulse
module activation_sequencer #(
  parameter int DWIDTH      = 8,
  parameter int DESIGN_SIZE = 4,
  parameter int ROW_CNT_W   = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ROW_CNT_W-1:0]          cfg_num_rows,
  input  logic                          cfg_act_type,
  input  logic                          cfg_enable,
  input  logic                          src_valid,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] src_data,
  output logic                          src_ready,
  output logic                          act_type,
  output logic                          act_enable,
  output logic                          act_in_valid,
  output logic [DESIGN_SIZE*DWIDTH-1:0] act_in_data,
  input  logic                          act_out_valid,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] act_out_data,
  output logic                          dst_valid,
  output logic [DESIGN_SIZE*DWIDTH-1:0] dst_data,
  input  logic                          dst_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int RW = DESIGN_SIZE * DWIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state;
  logic [ROW_CNT_W-1:0] num_rows;
  logic [ROW_CNT_W-1:0] issued_cnt;
  logic [ROW_CNT_W-1:0] recv_cnt;

  logic [RW-1:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        fifo_count;

  logic [CW-1:0]        inflight;
  logic [CW:0]          credit_sum;
  logic                 credit_ok;
  logic                 start_acc;
  logic                 src_hs;
  logic                 pop;
  logic                 fifo_full;
  logic                 push_err;
  logic                 push_ok;

  // Credit is computed from registered counters only, so src_ready never
  // depends combinationally on the unit's return path or on dst_ready.
  // Inflight is bounded by FIFO_DEPTH through the credit, so the narrow
  // view of the row-count difference is exact.
  assign inflight   = CW'(issued_cnt - recv_cnt);
  assign credit_sum = {1'b0, inflight} + {1'b0, fifo_count};
  assign credit_ok  = credit_sum < DEPTH_EXT;

  assign start_acc  = (state == S_IDLE) && start;
  assign src_ready  = (state == S_ISSUE) && credit_ok && (issued_cnt < num_rows);
  assign src_hs     = src_valid && src_ready;
  assign busy       = (state != S_IDLE);

  assign dst_valid  = (fifo_count != '0);
  assign dst_data   = mem[rd_ptr];
  assign pop        = dst_valid && dst_ready;
  assign fifo_full  = (fifo_count == FULL_CNT);

  // A result with nothing outstanding, or one that would overflow the FIFO,
  // is a protocol violation: the beat is dropped and flagged.
  assign push_err   = act_out_valid && ((issued_cnt == recv_cnt) || (fifo_full && !pop));
  assign push_ok    = act_out_valid && !push_err;

  // Sequencing FSM: config latch, row issue to the unit, completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      num_rows     <= '0;
      act_type     <= 1'b0;
      act_enable   <= 1'b0;
      issued_cnt   <= '0;
      act_in_valid <= 1'b0;
      act_in_data  <= '0;
      done         <= 1'b0;
    end else begin
      act_in_valid <= 1'b0;
      done         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            num_rows   <= cfg_num_rows;
            act_type   <= cfg_act_type;
            act_enable <= cfg_enable;
            issued_cnt <= '0;
            if (cfg_num_rows == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (src_hs) begin
            act_in_valid <= 1'b1;
            act_in_data  <= src_data;
            issued_cnt   <= issued_cnt + ROW_CNT_W'(1);
            if ((issued_cnt + ROW_CNT_W'(1)) == num_rows) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((recv_cnt == num_rows) && (fifo_count == '0)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Result collection into the output FIFO, independent of FSM state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      recv_cnt   <= '0;
      err        <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= act_out_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (start_acc) recv_cnt <= '0;
      else if (push_ok) recv_cnt <= recv_cnt + ROW_CNT_W'(1);
      if (push_err) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_activation_sequencer.sv
// Bench for activation_sequencer: a behavioural activation unit with
// configurable latency, a count-based reference model of tile progress,
// a table of directed tiles, hand-written corner sequences and random tiles.
module tb_activation_sequencer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  cfg_num_rows;
  logic        cfg_act_type;
  logic        cfg_enable;
  logic        src_valid;
  logic [31:0] src_data;
  logic        src_ready;
  logic        act_type;
  logic        act_enable;
  logic        act_in_valid;
  logic [31:0] act_in_data;
  logic        act_out_valid;
  logic [31:0] act_out_data;
  logic        dst_valid;
  logic [31:0] dst_data;
  logic        dst_ready;
  logic        busy;
  logic        done;
  logic        err;

  activation_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .cfg_num_rows(cfg_num_rows),
    .cfg_act_type(cfg_act_type), .cfg_enable(cfg_enable),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .act_type(act_type), .act_enable(act_enable),
    .act_in_valid(act_in_valid), .act_in_data(act_in_data),
    .act_out_valid(act_out_valid), .act_out_data(act_out_data),
    .dst_valid(dst_valid), .dst_data(dst_data), .dst_ready(dst_ready),
    .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int  due;
    logic [31:0] d;
  } ue_t;

  typedef struct {
    int n; bit typ; bit en; int lat; int pv; int pr;
    int exp_in; int exp_done; bit exp_err;
  } vec_t;

  int total, bad;
  int cyc, lat, src_prob, dst_prob;
  ue_t uq[$];

  // reference model: progress of the current tile expressed as row counts
  int  m_n, m_acc, m_recv, m_pop;
  bit  m_busy, m_done_now, m_err, m_type, m_en, m_inv;
  logic [31:0] m_indata;
  logic [31:0] e_q[$];

  int obs_hs, obs_inv, obs_done;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // behaviour of the activation unit: ReLU, or saturation to [-32,31] as tanh
  function automatic logic [31:0] act_fn(logic [31:0] r, logic t, logic e);
    logic [31:0] o;
    logic signed [7:0] x;
    o = r;
    if (e) begin
      for (int i = 0; i < 4; i++) begin
        x = r[i*8 +: 8];
        if (!t) o[i*8 +: 8] = (x < 0) ? 8'sd0 : x;
        else if (x > 31) o[i*8 +: 8] = 8'sd31;
        else if (x < -32) o[i*8 +: 8] = -8'sd32;
        else o[i*8 +: 8] = x;
      end
    end
    return o;
  endfunction

  task automatic model_clear();
    m_n = 0; m_acc = 0; m_recv = 0; m_pop = 0;
    m_busy = 0; m_done_now = 0; m_err = 0; m_type = 0; m_en = 0; m_inv = 0;
    m_indata = '0;
    e_q.delete();
    uq.delete();
  endtask

  task automatic monitor();
    bit exp_sr, exp_dv, hs, pe, nb, nd;
    exp_sr = m_busy && (m_acc < m_n) && ((m_acc - m_pop) < DEPTH);
    exp_dv = (m_recv > m_pop);
    chk("busy", busy, m_busy);
    chk("src_ready", src_ready, exp_sr);
    chk("done", done, m_done_now);
    chk("dst_valid", dst_valid, exp_dv);
    chk("err", err, m_err);
    chk("act_type", act_type, m_type);
    chk("act_enable", act_enable, m_en);
    chk("act_in_valid", act_in_valid, m_inv);
    if (exp_dv) chk("dst_data", dst_data, e_q[m_pop]);
    if (m_inv) chk("act_in_data", act_in_data, m_indata);

    if (src_valid && src_ready) obs_hs++;
    if (act_in_valid) obs_inv++;
    if (done) obs_done++;
    if (act_in_valid) uq.push_back('{cyc + lat, act_fn(act_in_data, act_type, act_enable)});

    hs = src_valid && exp_sr;
    pe = exp_dv && dst_ready;
    nb = m_busy;
    nd = 0;
    if (m_done_now) nb = 0;
    else if (m_busy && m_n > 0 && m_acc == m_n && m_pop == m_n) nd = 1;
    if (act_out_valid) begin
      if (m_acc == m_recv || ((m_recv - m_pop) == DEPTH && !pe)) m_err = 1;
      else m_recv++;
    end
    m_inv = hs;
    if (hs) begin
      e_q.push_back(act_fn(src_data, m_type, m_en));
      m_acc++;
      m_indata = src_data;
    end
    if (pe) m_pop++;
    if (!m_busy && start) begin
      m_n = int'(cfg_num_rows); m_type = cfg_act_type; m_en = cfg_enable;
      m_acc = 0; m_recv = 0; m_pop = 0;
      e_q.delete();
      nb = 1;
      if (cfg_num_rows == 0) nd = 1;
    end
    m_busy = nb;
    m_done_now = nd;
  endtask

  task automatic step(bit st, bit inj);
    ue_t u;
    @(posedge clk);
    cyc++;
    #1;
    start     = st;
    src_valid = ($urandom_range(99) < src_prob);
    src_data  = $urandom();
    dst_ready = ($urandom_range(99) < dst_prob);
    if (inj) begin
      act_out_valid = 1'b1;
      act_out_data  = $urandom();
    end else if (uq.size() > 0 && uq[0].due == cyc) begin
      u = uq.pop_front();
      act_out_valid = 1'b1;
      act_out_data  = u.d;
    end else begin
      act_out_valid = 1'b0;
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0; src_valid = 1'b0; dst_ready = 1'b0; act_out_valid = 1'b0;
    #2;
    chk("rst busy", busy, 1'b0);
    chk("rst dst_valid", dst_valid, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst src_ready", src_ready, 1'b0);
    chk("rst act_in_valid", act_in_valid, 1'b0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic run_tile(string name, int n, bit t, bit e, int l, int pv, int pr,
                          int exp_in, int exp_done, bit exp_err);
    int b_inv, b_done;
    b_inv = obs_inv; b_done = obs_done;
    cfg_num_rows = 8'(n); cfg_act_type = t; cfg_enable = e;
    lat = l; src_prob = pv; dst_prob = pr;
    step(1, 0);
    for (int k = 0; k < 3000 && obs_done == b_done; k++) step(0, 0);
    step(0, 0);
    step(0, 0);
    chk({name, " in_pulses"}, obs_inv - b_inv, exp_in);
    chk({name, " done_pulses"}, obs_done - b_done, exp_done);
    chk({name, " err"}, err, exp_err);
    chk({name, " idle"}, busy, 1'b0);
  endtask

  initial begin
    vec_t vt[6];
    int b_hs, b_inv, b_done, n;
    bit t, e;

    total = 0; bad = 0; cyc = 0; lat = 1; src_prob = 0; dst_prob = 0;
    obs_hs = 0; obs_inv = 0; obs_done = 0;
    reset = 1'b0; start = 1'b0; cfg_num_rows = '0; cfg_act_type = 1'b0; cfg_enable = 1'b0;
    src_valid = 1'b0; src_data = '0; act_out_valid = 1'b0; act_out_data = '0; dst_ready = 1'b0;
    model_clear();

    @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset src_ready", src_ready, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset err", err, 1'b0);
    chk("reset dst_valid", dst_valid, 1'b0);
    chk("reset dst_data", dst_data, 32'h0);
    chk("reset act_in_valid", act_in_valid, 1'b0);
    chk("reset act_in_data", act_in_data, 32'h0);
    chk("reset act_type", act_type, 1'b0);
    chk("reset act_enable", act_enable, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(0, 0);

    //           n  typ en lat  pv   pr  in done err
    vt[0] = '{   4, 0, 1, 2, 100, 100,   4, 1, 0};
    vt[1] = '{   0, 0, 1, 1, 100, 100,   0, 1, 0};
    vt[2] = '{   5, 1, 0, 1, 100, 100,   5, 1, 0};
    vt[3] = '{   6, 1, 1, 3,  60,  40,   6, 1, 0};
    vt[4] = '{   1, 0, 1, 1, 100,  30,   1, 1, 0};
    vt[5] = '{  12, 0, 1, 2,  50, 100,  12, 1, 0};
    for (int i = 0; i < 6; i++)
      run_tile($sformatf("vec%0d", i), vt[i].n, vt[i].typ, vt[i].en, vt[i].lat,
               vt[i].pv, vt[i].pr, vt[i].exp_in, vt[i].exp_done, vt[i].exp_err);

    // FIFO fills with dst blocked: exactly DEPTH rows accepted, then drain
    b_hs = obs_hs; b_inv = obs_inv; b_done = obs_done;
    cfg_num_rows = 8'd8; cfg_act_type = 1'b1; cfg_enable = 1'b1;
    lat = 2; src_prob = 100; dst_prob = 0;
    step(1, 0);
    repeat (20) step(0, 0);
    chk("full accepts", obs_hs - b_hs, 4);
    chk("full src_ready", src_ready, 1'b0);
    chk("full dst_valid", dst_valid, 1'b1);
    chk("full err", err, 1'b0);
    dst_prob = 100;
    for (int k = 0; k < 200 && obs_done == b_done; k++) step(0, 0);
    step(0, 0);
    chk("full in_pulses", obs_inv - b_inv, 8);
    chk("full done_pulses", obs_done - b_done, 1);
    chk("full err end", err, 1'b0);

    // start re-pulsed during ISSUE with different config is ignored
    b_inv = obs_inv; b_done = obs_done;
    cfg_num_rows = 8'd6; cfg_act_type = 1'b1; cfg_enable = 1'b1;
    lat = 2; src_prob = 70; dst_prob = 100;
    step(1, 0);
    step(0, 0);
    step(0, 0);
    cfg_num_rows = 8'd2; cfg_act_type = 1'b0;
    step(1, 0);
    for (int k = 0; k < 300 && obs_done == b_done; k++) step(0, 0);
    step(0, 0);
    chk("restart in_pulses", obs_inv - b_inv, 6);
    chk("restart done_pulses", obs_done - b_done, 1);
    chk("restart act_type", act_type, 1'b1);

    // reset during DRAIN with two rows held in the FIFO
    b_done = obs_done;
    cfg_num_rows = 8'd2; cfg_act_type = 1'b0; cfg_enable = 1'b1;
    lat = 1; src_prob = 100; dst_prob = 0;
    step(1, 0);
    repeat (8) step(0, 0);
    chk("pre-reset dst_valid", dst_valid, 1'b1);
    chk("pre-reset busy", busy, 1'b1);
    apply_reset();
    src_prob = 0;
    repeat (4) step(0, 0);
    chk("no done after reset", obs_done - b_done, 0);
    run_tile("post-reset", 3, 0, 1, 2, 100, 100, 3, 1, 0);

    // random tiles
    for (int i = 0; i < 12; i++) begin
      n = $urandom_range(1, 20);
      t = 1'($urandom_range(1));
      e = 1'($urandom_range(1));
      run_tile($sformatf("rnd%0d", i), n, t, e, e ? $urandom_range(1, 3) : 1,
               $urandom_range(30, 100), $urandom_range(20, 100), n, 1, 0);
    end

    // stray result in IDLE sets sticky err and is dropped
    src_prob = 0; dst_prob = 100;
    step(0, 1);
    step(0, 0);
    chk("inject err", err, 1'b1);
    chk("inject dst_valid", dst_valid, 1'b0);
    repeat (3) step(0, 0);
    chk("inject err sticky", err, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
